// File: rtl/rf_cmd_pkg.sv
// Shared definitions for the register-file command front-end:
// FSM state encoding, default opcodes and error codes.
package rf_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_TX_HOLD = 3'd5
    } state_e;

    localparam logic [7:0] DEF_WR_CMD = 8'hAA;
    localparam logic [7:0] DEF_RD_CMD = 8'hBB;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OPCODE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    // States in which the inter-byte / read-response watchdog runs.
    function automatic logic is_timed(input state_e s);
        return (s == ST_WR_ADDR) || (s == ST_WR_DATA) ||
               (s == ST_RD_ADDR) || (s == ST_RD_WAIT);
    endfunction

endpackage

// File: rtl/rf_cmd_timer.sv
// Saturating cycle counter used as a watchdog. Clear has priority over
// enable; expired_o is high while the count sits at LIMIT.
module rf_cmd_timer
    import rf_cmd_pkg::*;
#(
    parameter int unsigned LIMIT = 1023
) (
    input  logic clk,
    input  logic srst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear, otherwise count up and stick at LIMIT.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT_C)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT_C);

endmodule

// File: rtl/rf_cmd_ctrl.sv
// Command front-end for the register file: parses UART byte frames
// (write: WR_CMD,addr,data / read: RD_CMD,addr) into single-cycle
// WrEn/RdEn accesses and returns read data as one TX byte.
module rf_cmd_ctrl
    import rf_cmd_pkg::*;
#(
    parameter int unsigned            REG_WIDTH      = 8,
    parameter int unsigned            ADDR_WIDTH     = 4,
    parameter logic [REG_WIDTH-1:0]   WR_CMD         = DEF_WR_CMD,
    parameter logic [REG_WIDTH-1:0]   RD_CMD         = DEF_RD_CMD,
    parameter int unsigned            TIMEOUT_CYCLES = 1023
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_WIDTH-1:0]  RX_P_Data,
    input  logic                  RX_D_Valid,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [REG_WIDTH-1:0]  WrData,
    input  logic [REG_WIDTH-1:0]  RdData,
    input  logic                  RdData_Valid,
    output logic [REG_WIDTH-1:0]  TX_P_Data,
    output logic                  TX_D_Valid,
    input  logic                  TX_Busy,
    output logic                  Busy,
    output logic                  Err_Flag,
    output logic [1:0]            Err_Code
);

    state_e                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   addr_lat_q, addr_lat_d;
    logic [REG_WIDTH-1:0]    hold_q,     hold_d;
    logic                    wr_en_q,    wr_en_d;
    logic                    rd_en_q,    rd_en_d;
    logic [ADDR_WIDTH-1:0]   address_q,  address_d;
    logic [REG_WIDTH-1:0]    wr_data_q,  wr_data_d;
    logic [REG_WIDTH-1:0]    tx_data_q,  tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    err_flag_q, err_flag_d;
    logic [1:0]              err_code_q, err_code_d;
    logic                    busy_q;

    logic                    timer_clr;
    logic                    timer_en;
    logic                    timer_expired;

    // The watchdog restarts on every state change and on any received
    // byte, so a byte arriving on the expiry cycle always wins.
    assign timer_en  = is_timed(state_q);
    assign timer_clr = !is_timed(state_q) || (state_d != state_q) || RX_D_Valid;

    rf_cmd_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (CLK),
        .srst      (RST),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    // Next-state and registered-output decode; strobes and the access
    // address/data default to zero so they are single-cycle pulses.
    always_comb begin
        state_d    = state_q;
        addr_lat_d = addr_lat_q;
        hold_d     = hold_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        address_d  = '0;
        wr_data_d  = '0;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        err_flag_d = 1'b0;
        err_code_d = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (RX_D_Valid) begin
                    if (RX_P_Data == WR_CMD) begin
                        state_d = ST_WR_ADDR;
                    end else if (RX_P_Data == RD_CMD) begin
                        state_d = ST_RD_ADDR;
                    end else begin
                        err_flag_d = 1'b1;
                        err_code_d = ERR_OPCODE;
                    end
                end
            end

            ST_WR_ADDR: begin
                if (RX_D_Valid) begin
                    addr_lat_d = RX_P_Data[ADDR_WIDTH-1:0];
                    state_d    = ST_WR_DATA;
                end else if (timer_expired) begin
                    state_d    = ST_IDLE;
                    err_flag_d = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end

            ST_WR_DATA: begin
                if (RX_D_Valid) begin
                    wr_en_d   = 1'b1;
                    address_d = addr_lat_q;
                    wr_data_d = RX_P_Data;
                    state_d   = ST_IDLE;
                end else if (timer_expired) begin
                    state_d    = ST_IDLE;
                    err_flag_d = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end

            ST_RD_ADDR: begin
                if (RX_D_Valid) begin
                    rd_en_d   = 1'b1;
                    address_d = RX_P_Data[ADDR_WIDTH-1:0];
                    state_d   = ST_RD_WAIT;
                end else if (timer_expired) begin
                    state_d    = ST_IDLE;
                    err_flag_d = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end

            ST_RD_WAIT: begin
                // A byte here is dropped as an overrun; read data still
                // completes the access if it lands in the same cycle.
                if (RX_D_Valid) begin
                    err_flag_d = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
                if (RdData_Valid) begin
                    hold_d  = RdData;
                    state_d = ST_TX_HOLD;
                end else if (timer_expired && !RX_D_Valid) begin
                    state_d    = ST_IDLE;
                    err_flag_d = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end

            ST_TX_HOLD: begin
                if (RX_D_Valid) begin
                    err_flag_d = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
                if (!TX_Busy) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = hold_q;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            addr_lat_q <= '0;
            hold_q     <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            address_q  <= '0;
            wr_data_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_flag_q <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_lat_q <= addr_lat_d;
            hold_q     <= hold_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            address_q  <= address_d;
            wr_data_q  <= wr_data_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_flag_q <= err_flag_d;
            err_code_q <= err_code_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign WrEn       = wr_en_q;
    assign RdEn       = rd_en_q;
    assign Address    = address_q;
    assign WrData     = wr_data_q;
    assign TX_P_Data  = tx_data_q;
    assign TX_D_Valid = tx_valid_q;
    assign Busy       = busy_q;
    assign Err_Flag   = err_flag_q;
    assign Err_Code   = err_code_q;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Scoreboard bench for rf_cmd_ctrl: the driver issues frames and pushes the
// expected strobes/bytes/errors into queues; a monitor pops and compares
// whenever the DUT pulses an output. A simple register-file model answers reads.
module tb_rf_cmd_ctrl;

    localparam int TMO = 1023;
    localparam logic [7:0] WRC = 8'hAA;
    localparam logic [7:0] RDC = 8'hBB;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_Data = '0;
    logic       RX_D_Valid = 1'b0;
    logic       WrEn, RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] RdData = '0;
    logic       RdData_Valid = 1'b0;
    logic [7:0] TX_P_Data;
    logic       TX_D_Valid;
    logic       TX_Busy = 1'b0;
    logic       Busy, Err_Flag;
    logic [1:0] Err_Code;

    always #5 CLK = ~CLK;

    rf_cmd_ctrl #(
        .REG_WIDTH(8), .ADDR_WIDTH(4), .WR_CMD(WRC), .RD_CMD(RDC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_Data(RX_P_Data), .RX_D_Valid(RX_D_Valid),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .TX_P_Data(TX_P_Data), .TX_D_Valid(TX_D_Valid), .TX_Busy(TX_Busy),
        .Busy(Busy), .Err_Flag(Err_Flag), .Err_Code(Err_Code)
    );

    typedef struct {
        int val;
        int cyc;   // -1 = timing not checked
    } exp_t;

    exp_t q_wr[$];
    exp_t q_rd[$];
    exp_t q_tx[$];
    exp_t q_err[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic rst_seen = 1'b1;
    int byte_cyc = 0;

    logic [7:0] ref_mem [16] = '{default: 8'h00};
    logic [7:0] rf_mem  [16] = '{default: 8'h00};
    int rf_lat = 1;
    int rf_pend = 0;
    logic [3:0] rf_addr = '0;

    int last_code = 0;
    int last_tx = 0;

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rst_seen <= RST;
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        total++;
        bad++;
        $display("FAIL %s actual=%0h required=no_pulse (cycle %0d)", name, act, cyc);
    endtask

    // Register-file model: write on WrEn, answer RdEn after rf_lat cycles
    // (rf_lat = 0 means the read is never answered).
    always @(negedge CLK) begin
        RdData_Valid = 1'b0;
        if (rf_pend > 0) begin
            rf_pend = rf_pend - 1;
            if (rf_pend == 0) begin
                RdData_Valid = 1'b1;
                RdData = rf_mem[rf_addr];
            end
        end
        if (WrEn) rf_mem[Address] = WrData;
        if (RdEn && rf_lat > 0) begin
            rf_pend = rf_lat;
            rf_addr = Address;
        end
    end

    // Monitor: one line per observed transaction, compare against queues.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (rst_seen) begin
            last_code = 0;
            last_tx = 0;
        end else begin
            if (WrEn) begin
                if (q_wr.size() == 0) unexpected("wr_strobe", int'({Address, WrData}));
                else begin
                    e = q_wr.pop_front();
                    $display("WR  addr=%0h data=%02h cycle=%0d", Address, WrData, cyc);
                    chk("wr_addr_data", int'({Address, WrData}), e.val);
                    if (e.cyc >= 0) chk("wr_cycle", cyc, e.cyc);
                end
            end else begin
                chk("wrdata_idle", int'(WrData), 0);
            end
            if (RdEn) begin
                if (q_rd.size() == 0) unexpected("rd_strobe", int'(Address));
                else begin
                    e = q_rd.pop_front();
                    $display("RD  addr=%0h cycle=%0d", Address, cyc);
                    chk("rd_addr", int'(Address), e.val);
                    if (e.cyc >= 0) chk("rd_cycle", cyc, e.cyc);
                end
            end
            if (WrEn && RdEn) unexpected("wr_rd_together", 1);
            if (!WrEn && !RdEn) chk("addr_idle", int'(Address), 0);
            if (TX_D_Valid) begin
                if (q_tx.size() == 0) unexpected("tx_push", int'(TX_P_Data));
                else begin
                    e = q_tx.pop_front();
                    $display("TX  data=%02h cycle=%0d", TX_P_Data, cyc);
                    chk("tx_data", int'(TX_P_Data), e.val);
                    if (e.cyc >= 0) chk("tx_cycle", cyc, e.cyc);
                    last_tx = e.val;
                end
            end else begin
                chk("tx_data_hold", int'(TX_P_Data), last_tx);
            end
            if (Err_Flag) begin
                if (q_err.size() == 0) unexpected("err_pulse", int'(Err_Code));
                else begin
                    e = q_err.pop_front();
                    $display("ERR code=%0d cycle=%0d", Err_Code, cyc);
                    chk("err_code", int'(Err_Code), e.val);
                    if (e.cyc >= 0) chk("err_cycle", cyc, e.cyc);
                    last_code = e.val;
                end
            end else begin
                chk("err_code_hold", int'(Err_Code), last_code);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Present one byte for one cycle; called on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        RX_P_Data = b;
        RX_D_Valid = 1'b1;
        byte_cyc = cyc;
        @(negedge CLK);
        RX_D_Valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] ab, input logic [7:0] d, input int gap_a, input int gap_d);
        logic [3:0] a;
        a = ab[3:0];
        send_byte(WRC);
        idle(gap_a);
        send_byte(ab);
        idle(gap_d);
        send_byte(d);
        q_wr.push_back('{int'({a, d}), byte_cyc + 1});
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [7:0] ab, input int lat, input int bp, input bit ovr, input int gap);
        logic [3:0] a;
        a = ab[3:0];
        rf_lat = lat;
        if (bp > 0) TX_Busy = 1'b1;
        send_byte(RDC);
        idle(gap);
        send_byte(ab);
        q_rd.push_back('{int'(a), byte_cyc + 1});
        if (lat == 0) begin
            q_err.push_back('{2, byte_cyc + TMO + 2});
            idle(TMO + 4);
        end else begin
            if (ovr) begin
                send_byte(8'($urandom_range(0, 255)));
                q_err.push_back('{3, byte_cyc + 1});
            end
            if (bp == 0) begin
                q_tx.push_back('{int'(ref_mem[a]), -1});
            end else begin
                idle(bp);
                q_tx.push_back('{int'(ref_mem[a]), cyc + 1});
                TX_Busy = 1'b0;
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q_wr.size() + q_rd.size() + q_tx.size() + q_err.size()) != 0 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL drain actual=%0d_pending required=0", q_wr.size() + q_rd.size() + q_tx.size() + q_err.size());
        end
        idle(2);
        chk("busy_idle", int'(Busy), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wren"}, int'(WrEn), 0);
        chk({tag, "_rden"}, int'(RdEn), 0);
        chk({tag, "_addr"}, int'(Address), 0);
        chk({tag, "_wrdata"}, int'(WrData), 0);
        chk({tag, "_txdata"}, int'(TX_P_Data), 0);
        chk({tag, "_txvalid"}, int'(TX_D_Valid), 0);
        chk({tag, "_busy"}, int'(Busy), 0);
        chk({tag, "_errflag"}, int'(Err_Flag), 0);
        chk({tag, "_errcode"}, int'(Err_Code), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind, lat, bp;
        logic [7:0] b;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk_outputs_zero("reset");
        RST = 1'b0;
        idle(2);

        // Two writes to the same register, second overwrites the first.
        do_write(8'h01, 8'h0F, 0, 0);
        wait_done();
        do_write(8'h01, 8'h05, 0, 0);
        wait_done();
        chk("reg1_value", int'(rf_mem[1]), 8'h05);

        // Write then read back.
        do_write(8'h07, 8'h64, 1, 1);
        wait_done();
        do_read(8'h07, 1, 0, 0, 0);
        wait_done();

        // TX backpressure, short and longer than the watchdog period.
        do_write(8'h0A, 8'hC8, 0, 2);
        wait_done();
        do_read(8'h0A, 2, 20, 0, 0);
        wait_done();
        do_read(8'h0A, 3, TMO + 80, 0, 1);
        wait_done();

        // Bad opcode.
        send_byte(8'h3C);
        q_err.push_back('{1, byte_cyc + 1});
        wait_done();

        // Write frame abandoned after the address byte.
        send_byte(WRC);
        send_byte(8'h02);
        q_err.push_back('{2, byte_cyc + TMO + 2});
        idle(TMO + 4);
        wait_done();

        // Read never answered by the register file.
        do_read(8'h05, 0, 0, 0, 0);
        wait_done();

        // Byte arriving while a read is outstanding.
        do_read(8'h07, 4, 0, 1, 0);
        wait_done();

        // Data byte exactly on the expiry cycle is still accepted.
        do_write(8'h09, 8'h5A, 0, TMO);
        wait_done();

        // One cycle later the frame times out; the late byte is then a bad opcode.
        send_byte(WRC);
        send_byte(8'h0B);
        q_err.push_back('{2, byte_cyc + TMO + 2});
        idle(TMO + 1);
        send_byte(8'h12);
        q_err.push_back('{1, byte_cyc + 1});
        wait_done();

        // Reset in the middle of a write frame.
        send_byte(WRC);
        send_byte(8'h03);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk_outputs_zero("midreset");
        idle(2);
        send_byte(8'h55);
        q_err.push_back('{1, byte_cyc + 1});
        wait_done();
        do_write(8'h03, 8'h11, 0, 0);
        wait_done();
        chk("reg3_value", int'(rf_mem[3]), 8'h11);

        // Randomised traffic.
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                         $urandom_range(0, 3), $urandom_range(0, 3));
                wait_done();
            end else if (kind <= 6 || kind == 8) begin
                lat = $urandom_range(1, 4);
                bp = ($urandom_range(0, 2) == 0) ? lat + 4 + $urandom_range(0, 10) : 0;
                do_read(8'($urandom_range(0, 255)), lat, bp, (kind == 8), $urandom_range(0, 3));
                wait_done();
            end else if (kind == 7) begin
                do b = 8'($urandom_range(0, 255)); while (b == WRC || b == RDC);
                send_byte(b);
                q_err.push_back('{1, byte_cyc + 1});
                wait_done();
            end else begin
                do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0);
                do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0);
                wait_done();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_cmd_ctrl.md
Name: rf_cmd_ctrl

Overview:
Command front-end that sits directly upstream of the Register_File. It parses byte frames arriving from the UART receiver and turns them into single-cycle WrEn/RdEn accesses. Read results are returned as one byte towards the UART transmit path. It is the only master of the register-file access port.

Parameters:
REG_WIDTH, 8, width of RX/TX bytes and register data
ADDR_WIDTH, 4, register-file address width
WR_CMD, 8'hAA, opcode for a write frame: WR_CMD, addr, data
RD_CMD, 8'hBB, opcode for a read frame: RD_CMD, addr
TIMEOUT_CYCLES, 1023, idle cycles allowed between frame bytes or while awaiting RdData_Valid

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
RX_P_Data  in  REG_WIDTH  received byte
RX_D_Valid  in  1  one cycle high per received byte
WrEn  out  1  register-file write strobe
RdEn  out  1  register-file read strobe
Address  out  ADDR_WIDTH  register-file address
WrData  out  REG_WIDTH  register-file write data
RdData  in  REG_WIDTH  register-file read data
RdData_Valid  in  1  register-file read-data qualifier
TX_P_Data  out  REG_WIDTH  byte to the transmit path
TX_D_Valid  out  1  one-cycle push to the transmit path
TX_Busy  in  1  transmit path cannot accept a byte
Busy  out  1  high whenever state != IDLE
Err_Flag  out  1  one-cycle error pulse
Err_Code  out  2  valid with Err_Flag: 01 bad opcode, 10 timeout, 11 overrun

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. During reset, all outputs are 0 and the state is IDLE. Reset mid-frame discards the partial frame, the latched address and any pending TX byte.
- All outputs are registered.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_HOLD.
- IDLE:
  - RX_D_Valid with byte == WR_CMD -> WR_ADDR.
  - RX_D_Valid with byte == RD_CMD -> RD_ADDR.
  - Any other byte: Err_Flag=1, Err_Code=01, stay in IDLE.
- WR_ADDR: on RX_D_Valid, latch byte[ADDR_WIDTH-1:0]; upper bits are ignored. -> WR_DATA.
- WR_DATA: on RX_D_Valid at edge N, set WrEn<=1, Address<=latched address, WrData<=byte. At edge N+1 (the register-file write edge), WrEn<=0, WrData<=0 and Address<=0. -> IDLE. A new opcode is accepted in the cycle after edge N.
- RD_ADDR: on RX_D_Valid at edge N, set RdEn<=1 and Address<=byte[ADDR_WIDTH-1:0]. RdEn is a one-cycle pulse; Address returns to 0 together with RdEn. -> RD_WAIT.
- RD_WAIT: on RdData_Valid, capture RdData into the TX holding register. -> TX_HOLD.
- TX_HOLD:
  - If TX_Busy==0: TX_D_Valid<=1 for exactly one cycle with TX_P_Data = captured byte. -> IDLE.
  - If TX_Busy==1: hold with no timeout.
  - TX_P_Data keeps its last value after the push.
- Overrun: RX_D_Valid in RD_WAIT or TX_HOLD drops the byte, pulses Err_Flag with Err_Code=11, and does not change state.
- Timeout counter:
  - Runs in WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT.
  - Clears on state entry and on every accepted byte.
  - When the count reaches TIMEOUT_CYCLES: -> IDLE, Err_Flag=1, Err_Code=10. No strobe is issued.
  - Width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Simultaneous events:
  - Timeout expiry and RX_D_Valid in the same cycle: the byte wins and the counter clears.
  - RdData_Valid outside RD_WAIT is ignored.
- Err_Flag pulses are mutually exclusive per cycle. Err_Code holds its value until the next error.

Decomposition:
- Package rf_cmd_pkg: state encoding, default opcodes (8'hAA, 8'hBB), Err_Code constants (ERR_OPCODE, ERR_TIMEOUT, ERR_OVERRUN).
- One sub-module, rf_cmd_timer: a parameterised saturating cycle counter with clear/enable inputs and an expired output.
- The FSM and datapath stay in rf_cmd_ctrl.

Test Plan:
- Write: RX bytes AA, 01, 0F, then AA, 01, 05 -> each frame gives one WrEn pulse with Address=1, first WrData=0x0F then 0x05, and Register_File REG1=0x05.
- Read: write 7<-0x64, then RX BB, 07 -> one RdEn pulse with Address=7, then one TX_D_Valid pulse with TX_P_Data=0x64, then Busy=0.
- Backpressure: TX_Busy=1 for 20 cycles during a read of address 10 (0xC8) -> TX_D_Valid stays 0 with no timeout; one pulse of 0xC8 on the cycle after TX_Busy falls.
- Errors: RX 0x3C in IDLE -> Err_Flag with code 01, no strobes. RX AA, 02, then silence for TIMEOUT_CYCLES -> code 10, IDLE, no WrEn. RX byte during RD_WAIT -> code 11.
- Reset: assert RST for one cycle after AA, 03 -> all outputs 0; a later 0x55 gives code 01; a full frame AA, 03, 11 still writes correctly.
